// File: rtl/mv_avg_filter_mc.sv
// mv_avg_filter_mc: multi-channel time-multiplexed boxcar moving average with runtime power-of-two window
module mv_avg_filter_mc #(
  parameter int DW = 32,
  parameter int N_CH = 4,
  parameter int LOG2_WIN_MAX = 13,
  parameter int DIV_FACTOR = 4,
  parameter int ACC_W = DW + LOG2_WIN_MAX,
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int WS_W = $clog2(LOG2_WIN_MAX + 1)
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   trig,
  input  logic [N_CH*DW-1:0]     din,
  input  logic [WS_W-1:0]        win_sel,
  input  logic                   clear,
  output logic signed [DW-1:0]   dout,
  output logic [CH_W-1:0]        dout_ch,
  output logic                   dout_valid,
  output logic                   filled,
  output logic                   busy,
  output logic                   overrun,
  output logic [DW-1:0]          monitor_sum
);
  localparam int TC_W = (DIV_FACTOR > 1) ? $clog2(DIV_FACTOR) : 1;
  localparam int IW = LOG2_WIN_MAX;
  localparam int FW = LOG2_WIN_MAX + 1;
  localparam int XW = ACC_W + 1;
  localparam int DEPTH = N_CH << LOG2_WIN_MAX;
  localparam logic [TC_W-1:0] TC_LAST = (DIV_FACTOR > 1) ? TC_W'(DIV_FACTOR - 1) : '0;
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(N_CH - 1);
  localparam logic [WS_W-1:0] L_MAX = WS_W'(LOG2_WIN_MAX);

  typedef enum logic [1:0] {IDLE, RD, UPD, DONE} state_t;

  state_t                   state_q, state_d;
  logic [TC_W-1:0]          trig_cnt_q, trig_cnt_d;
  logic [WS_W-1:0]          l_q, l_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic [FW-1:0]            fill_cnt_q, fill_cnt_d;
  logic                     filled_q, filled_d;
  logic [CH_W-1:0]          ch_q, ch_d;
  logic [N_CH*DW-1:0]       din_q, din_d;
  logic signed [ACC_W-1:0]  sum_q [N_CH];
  logic signed [ACC_W-1:0]  sum_d [N_CH];
  logic signed [DW-1:0]     dout_q, dout_d;
  logic [CH_W-1:0]          dout_ch_q, dout_ch_d;
  logic                     dout_valid_q, dout_valid_d;
  logic                     overrun_q, overrun_d;
  logic [DW-1:0]            monitor_sum_q, monitor_sum_d;

  logic [DW-1:0]            mem [DEPTH];
  logic [DW-1:0]            rd_q;

  logic                     sample, last_ch, we;
  logic [CH_W+IW-1:0]       addr;
  logic [FW-1:0]            win;
  logic signed [DW-1:0]     new_s, old_s;
  logic signed [ACC_W-1:0]  acc_new;
  logic signed [XW-1:0]     rnd;

  // Decimated sample event; the trig counter wraps every DIV_FACTOR trigs
  assign sample  = trig && (DIV_FACTOR <= 1 || trig_cnt_q == TC_LAST);
  assign win     = FW'(1) << l_q;
  assign last_ch = ch_q == CH_LAST;
  assign addr    = {ch_q, idx_q};
  assign we      = state_q == UPD;
  assign new_s   = din_q[ch_q*DW +: DW];
  // Until the window has been filled once, RAM contents are stale and treated as zero
  assign old_s   = filled_q ? rd_q : '0;
  assign acc_new = sum_q[ch_q] - ACC_W'(old_s) + ACC_W'(new_s);
  // Round half up: add W/2 before the arithmetic shift (W/2 is 0 when L is 0)
  assign rnd     = (XW'(acc_new) + signed'(XW'(win >> 1))) >>> l_q;

  // Single-port sample RAM: read in RD, write in UPD, never both in one cycle
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= new_s;
    else rd_q <= mem[addr];
  end

  // Next-state logic for the channel sweep, decimator, window bookkeeping and outputs
  always_comb begin
    state_d       = state_q;
    trig_cnt_d    = (!trig || DIV_FACTOR <= 1) ? trig_cnt_q :
                    (trig_cnt_q == TC_LAST ? '0 : trig_cnt_q + TC_W'(1));
    l_d           = l_q;
    idx_d         = idx_q;
    fill_cnt_d    = fill_cnt_q;
    filled_d      = filled_q;
    ch_d          = ch_q;
    din_d         = din_q;
    sum_d         = sum_q;
    dout_d        = dout_q;
    dout_ch_d     = dout_ch_q;
    dout_valid_d  = 1'b0;
    monitor_sum_d = monitor_sum_q;
    overrun_d     = sample && !clear && state_q != IDLE;
    if (clear) begin
      state_d       = IDLE;
      l_d           = (win_sel > L_MAX) ? L_MAX : win_sel;
      idx_d         = '0;
      fill_cnt_d    = '0;
      filled_d      = 1'b0;
      sum_d         = '{default: '0};
      dout_d        = '0;
      dout_ch_d     = '0;
      monitor_sum_d = '0;
    end else begin
      case (state_q)
        IDLE: if (sample) begin
          din_d   = din;
          ch_d    = '0;
          state_d = RD;
        end
        RD: state_d = UPD;
        UPD: begin
          sum_d[ch_q]   = acc_new;
          dout_d        = rnd[DW-1:0];
          dout_ch_d     = ch_q;
          monitor_sum_d = acc_new[DW-1:0];
          dout_valid_d  = 1'b1;
          ch_d          = last_ch ? ch_q : ch_q + CH_W'(1);
          state_d       = last_ch ? DONE : RD;
        end
        DONE: begin
          idx_d      = (idx_q + IW'(1)) & IW'(win - FW'(1));
          fill_cnt_d = (fill_cnt_q == win) ? fill_cnt_q : fill_cnt_q + FW'(1);
          filled_d   = fill_cnt_q + FW'(1) >= win;
          state_d    = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= IDLE;
      trig_cnt_q    <= '0;
      l_q           <= L_MAX;
      idx_q         <= '0;
      fill_cnt_q    <= '0;
      filled_q      <= 1'b0;
      ch_q          <= '0;
      din_q         <= '0;
      sum_q         <= '{default: '0};
      dout_q        <= '0;
      dout_ch_q     <= '0;
      dout_valid_q  <= 1'b0;
      overrun_q     <= 1'b0;
      monitor_sum_q <= '0;
    end else begin
      state_q       <= state_d;
      trig_cnt_q    <= trig_cnt_d;
      l_q           <= l_d;
      idx_q         <= idx_d;
      fill_cnt_q    <= fill_cnt_d;
      filled_q      <= filled_d;
      ch_q          <= ch_d;
      din_q         <= din_d;
      sum_q         <= sum_d;
      dout_q        <= dout_d;
      dout_ch_q     <= dout_ch_d;
      dout_valid_q  <= dout_valid_d;
      overrun_q     <= overrun_d;
      monitor_sum_q <= monitor_sum_d;
    end
  end

  assign dout        = dout_q;
  assign dout_ch     = dout_ch_q;
  assign dout_valid  = dout_valid_q;
  assign filled      = filled_q;
  assign busy        = state_q != IDLE;
  assign overrun     = overrun_q;
  assign monitor_sum = monitor_sum_q;
endmodule

// File: tb/tb_mv_avg_filter_mc.sv
// tb_mv_avg_filter_mc: random and directed checks of the moving-average filter against a window-sum model
module tb_mv_avg_filter_mc;
  localparam int DW = 16, N_CH = 3, LWM = 4, DIV = 3, CH_W = 2, WS_W = 3;
  localparam int INF = 1 << 30;

  logic clk = 0, n_rst = 0, trig = 0, clear = 0;
  logic [N_CH*DW-1:0] din = '0;
  logic [WS_W-1:0] win_sel = '0;
  logic signed [DW-1:0] dout;
  logic [CH_W-1:0] dout_ch;
  logic dout_valid, filled, busy, overrun;
  logic [DW-1:0] monitor_sum;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  mv_avg_filter_mc #(.DW(DW), .N_CH(N_CH), .LOG2_WIN_MAX(LWM), .DIV_FACTOR(DIV)) dut (
    .clk(clk), .n_rst(n_rst), .trig(trig), .din(din), .win_sel(win_sel), .clear(clear),
    .dout(dout), .dout_ch(dout_ch), .dout_valid(dout_valid), .filled(filled), .busy(busy),
    .overrun(overrun), .monitor_sum(monitor_sum)
  );

  typedef struct {int t; bit v; longint d; int ch; longint mon;} item_t;
  item_t q[$];
  int hist[N_CH][$];
  int cyc = 0, tc = 0, lw = LWM, cnt = 0, fill_at = INF, busy_lo = 1, busy_hi = 0, ov_at = -1;
  longint m_last[N_CH];
  longint got[N_CH];
  longint held_d = 0, held_mon = 0;
  int held_ch = 0, vcnt = 0, ov_cnt = 0, v0 = 0;
  int e_ch0[6] = '{25, 50, 75, 100, 100, 100};
  int e_ch1[6] = '{-10, -20, -30, -40, -40, -40};
  int e_wrap[5] = '{75, 50, 25, 0, 0};

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Mean of the window, rounded half up (floor division of sum + W/2)
  function automatic longint rdiv(longint s, longint w);
    longint n, r;
    n = s + w / 2;
    r = n / w;
    if (n < 0 && n % w != 0) r = r - 1;
    return r;
  endfunction

  task automatic model_reset();
    tc = 0; lw = LWM; cnt = 0; fill_at = INF; busy_hi = cyc - 1; ov_at = -1;
    for (int k = 0; k < N_CH; k++) hist[k].delete();
    q.delete();
  endtask

  // Reference model: per-channel history of accepted samples since clear, results scheduled by cycle
  always @(posedge clk) begin : model
    bit ev;
    int w;
    longint s;
    cyc++;
    if (!n_rst) model_reset();
    else begin
      ev = trig && tc == DIV - 1;
      if (trig) tc = (tc == DIV - 1) ? 0 : tc + 1;
      if (clear) begin
        lw = (win_sel > LWM) ? LWM : int'(win_sel);
        cnt = 0;
        for (int k = 0; k < N_CH; k++) hist[k].delete();
        while (q.size() > 0 && q[$].t >= cyc) void'(q.pop_back());
        q.push_back('{cyc, 1'b0, 0, 0, 0});
        busy_hi = cyc - 1;
        fill_at = INF;
      end else if (ev) begin
        if (cyc <= busy_hi + 1) ov_at = cyc;
        else begin
          w = 1 << lw;
          cnt++;
          busy_lo = cyc;
          busy_hi = cyc + 2 * N_CH;
          for (int k = 0; k < N_CH; k++) begin
            hist[k].push_back(int'($signed(din[k*DW +: DW])));
            if (hist[k].size() > w) void'(hist[k].pop_front());
            s = 0;
            foreach (hist[k][j]) s += hist[k][j];
            m_last[k] = rdiv(s, w);
            q.push_back('{cyc + 2 + 2 * k, 1'b1, m_last[k], k, s & ((64'd1 << DW) - 1)});
          end
          if (cnt >= w && fill_at == INF) fill_at = cyc + 2 * N_CH + 1;
        end
      end
    end
  end

  // Every-cycle comparison of all DUT outputs against the model, away from the active edge
  always @(negedge clk) begin : compare
    bit ev_v;
    item_t it;
    if (cyc > 0) begin
      if (!n_rst) begin
        chk("rst_dout", dout, 0);
        chk("rst_dout_ch", dout_ch, 0);
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_filled", filled, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_monitor_sum", monitor_sum, 0);
        held_d = 0; held_ch = 0; held_mon = 0;
      end else begin
        while (q.size() > 0 && q[0].t < cyc) void'(q.pop_front());
        ev_v = 0;
        if (q.size() > 0 && q[0].t == cyc) begin
          it = q.pop_front();
          ev_v = it.v; held_d = it.d; held_ch = it.ch; held_mon = it.mon;
        end
        chk("dout_valid", dout_valid, ev_v);
        chk("dout", dout, held_d);
        chk("dout_ch", dout_ch, held_ch);
        chk("monitor_sum", monitor_sum, held_mon);
        chk("filled", filled, cyc >= fill_at);
        chk("busy", busy, cyc >= busy_lo && cyc <= busy_hi);
        chk("overrun", overrun, cyc == ov_at);
      end
      if (dout_valid) begin vcnt++; got[dout_ch] = dout; end
      if (overrun) ov_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulses(int n);
    repeat (n) begin trig = 1; tick(); trig = 0; tick(); end
  endtask

  task automatic fire(int a, int b, int c);
    din = {DW'(c), DW'(b), DW'(a)};
    pulses(DIV - 1);
    trig = 1; tick(); trig = 0;
    repeat (2 * N_CH + 2) tick();
  endtask

  task automatic do_clear(int w);
    clear = 1; win_sel = WS_W'(w); tick(); clear = 0; tick();
  endtask

  task automatic do_reset();
    n_rst = 0; tick(); tick(); n_rst = 1; tick();
  endtask

  initial begin
    tick(); tick(); n_rst = 1; tick();
    for (int i = 0; i < 3000; i++) begin
      trig = ($urandom_range(2) == 0);
      clear = ($urandom_range(299) == 0);
      win_sel = WS_W'($urandom());
      din = (N_CH*DW)'({$urandom(), $urandom()});
      if (i == 1500) n_rst = 0;
      if (i == 1502) n_rst = 1;
      tick();
    end
    trig = 0; clear = 0;
    do_reset();
    do_clear(2);
    for (int i = 0; i < 6; i++) begin
      fire(100, -40, 7);
      chk("ramp_ch0", got[0], e_ch0[i]);
      chk("ramp_ch1", got[1], e_ch1[i]);
      chk("model_ramp_ch0", m_last[0], e_ch0[i]);
      if (i == 2) chk("filled_after_ev3", filled, 0);
      if (i == 3) chk("filled_after_ev4", filled, 1);
    end
    for (int i = 0; i < 5; i++) begin
      fire(0, 0, 0);
      chk("wrap_ch0", got[0], e_wrap[i]);
      chk("model_wrap_ch0", m_last[0], e_wrap[i]);
    end
    do_clear(2);
    fire(1, -1, 0); fire(2, -2, 0); fire(1, -1, 0); fire(2, -2, 0);
    chk("round_pos", got[0], 2);
    chk("round_neg", got[1], -1);
    chk("model_round_neg", m_last[1], -1);
    do_clear(2);
    v0 = ov_cnt;
    din = {DW'(0), DW'(0), DW'(8)};
    pulses(DIV - 1);
    trig = 1; tick();
    din = {DW'(0), DW'(0), DW'(100)};
    tick(); tick(); tick();
    trig = 0;
    repeat (8) tick();
    chk("overrun_count", ov_cnt - v0, 1);
    chk("overrun_first", got[0], 2);
    fire(4, 0, 0);
    chk("overrun_next", got[0], 3);
    din = {DW'(0), DW'(0), DW'(50)};
    pulses(DIV - 1);
    trig = 1; tick(); trig = 0; tick(); tick();
    clear = 1; win_sel = 3'd1; tick(); clear = 0;
    v0 = vcnt;
    repeat (10) tick();
    chk("clear_no_valid", vcnt - v0, 0);
    chk("clear_dout", dout, 0);
    chk("clear_busy", busy, 0);
    fire(9, 0, 0);
    chk("half_ev1", got[0], 5);
    chk("half_filled1", filled, 0);
    fire(9, 0, 0);
    chk("half_ev2", got[0], 9);
    chk("half_filled2", filled, 1);
    din = {DW'(0), DW'(0), DW'(50)};
    pulses(DIV - 1);
    trig = 1; tick(); trig = 0; tick();
    v0 = vcnt;
    n_rst = 0; tick(); tick(); n_rst = 1;
    repeat (10) tick();
    chk("rst_no_valid", vcnt - v0, 0);
    chk("rst_dout_after", dout, 0);
    chk("rst_filled_after", filled, 0);
    fire(32, 0, 0);
    chk("rst_window16", got[0], 2);
    v0 = vcnt;
    repeat (9) begin trig = 1; tick(); trig = 0; repeat (19) tick(); end
    repeat (5) tick();
    chk("decim_bursts", vcnt - v0, 3 * N_CH);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mv_avg_filter_mc.md
# mv_avg_filter_mc

Multi-channel, time-multiplexed boxcar moving-average filter with runtime-selectable power-of-two window, trigger decimation, rounding and warm-up tracking. It is the parametrised successor to the single-channel gated moving-average filter. It sits after the demodulation and accumulation stage and feeds per-channel averaged values to the output/register interface. All channels share one inferred sample RAM, processed sequentially by an FSM after each decimated trigger.

## Interface
- DW, 32, signed sample width (input and output).
- N_CH, 4, channel count (≥1); CH_W = max(1, clog2(N_CH)).
- LOG2_WIN_MAX, 13, log2 of maximum window; RAM depth N_CH·2^LOG2_WIN_MAX.
- DIV_FACTOR, 4, trig decimation; ≤1 means every trig is a sample event.
- ACC_W, DW+LOG2_WIN_MAX, per-channel signed accumulator width.

- clk  in  1  clock, all logic on rising edge.
- n_rst  in  1  asynchronous, active-low reset.
- trig  in  1  sample strobe, one-cycle pulses.
- din  in  N_CH·DW  packed signed samples, channel k at [k·DW +: DW].
- win_sel  in  clog2(LOG2_WIN_MAX+1)  requested log2 window, applied on clear.
- clear  in  1  synchronous flush, one-cycle pulse.
- dout  out  DW  signed averaged result.
- dout_ch  out  CH_W  channel index of dout.
- dout_valid  out  1  one-cycle pulse per channel result.
- filled  out  1  window fully populated since last clear/reset.
- busy  out  1  FSM not IDLE.
- overrun  out  1  one-cycle pulse: sample event dropped.
- monitor_sum  out  DW  low DW bits of updated accumulator of dout_ch.

## Operation
- Decimator: trig_cnt increments on each trig and wraps at DIV_FACTOR-1. A sample event fires on the trig at which trig_cnt == DIV_FACTOR-1, or on every trig when DIV_FACTOR ≤ 1. The counter advances even when the event is dropped.
- Active window L = min(win_sel, LOG2_WIN_MAX), latched only on clear; reset sets L = LOG2_WIN_MAX. W = 2^L.
- Sample event in IDLE: latch the whole din vector, set ch=0, go to RD.
- Sample event while busy: dropped, overrun pulses, no state change.
- FSM:
  - IDLE -> RD on a sample event.
  - RD: present RAM address {ch, idx}; -> UPD.
  - UPD: old = RAM q, or 0 if !filled. sum[ch] <= sum[ch] - old + new. Write new to {ch, idx}. Register dout, dout_ch, monitor_sum, and pulse dout_valid. If ch == N_CH-1 -> DONE, else ch++ and -> RD.
  - DONE: idx <= (idx+1) & (W-1); fill_cnt++ saturating at W; filled <= (fill_cnt+1 ≥ W); -> IDLE.
- Output: dout = (sum_new + (L>0 ? 2^(L-1) : 0)) >>> L, i.e. round-half-up arithmetic shift. The result always fits in DW; no saturation is needed.
- During warm-up, dout is the running sum divided by W (a ramp) and filled=0.
- clear: sums ← 0, idx ← 0, fill_cnt ← 0, filled ← 0, L latched, FSM → IDLE (aborts any burst, no further dout_valid). RAM is not zeroed; the fill gating masks stale data. clear takes priority over a same-cycle sample event, which is dropped without overrun.
- Reset values: dout 0, dout_ch 0, dout_valid 0, filled 0, busy 0, overrun 0, monitor_sum 0, sums 0, idx 0, fill_cnt 0, trig_cnt 0, FSM IDLE.

## Timing
- Sample event edge E0. Channel k result is registered at edge E0+2+2k; dout_valid is high for one cycle after it.
- busy is high for 2·N_CH+1 cycles per event. The minimum spacing between sample events is 2·N_CH+2 clk cycles.
- RAM is single-port with synchronous read (1-cycle). Read and write never address the same word in one cycle.
- Index wrap: after W events idx returns to 0. The (W+1)th event subtracts the sample written W events earlier.

## Test plan
- DIV_FACTOR=1, N_CH=2, DW=16, LOG2_WIN_MAX=3, clear with win_sel=2; ch0=100, ch1=-40 for 6 events -> ch0 dout 25,50,75,100,100,100; ch1 -10,-20,-30,-40,-40,-40; filled rises after event 4; dout_valid pulses at E0+3 (ch0) and E0+5 (ch1).
- Rounding, W=4: inputs 1,2,1,2 -> final sum 6 -> dout 2; inputs -1,-2,-1,-2 -> sum -6 -> dout -1.
- Wrap-around: filled window of 100 then step to 0 -> dout 75,50,25,0,0.
- DIV_FACTOR=4: 12 trig pulses spaced 20 cycles -> exactly 3 sample bursts, on trigs 4, 8 and 12.
- Overrun: second sample event 2 cycles after the first -> overrun pulse, only one burst, idx advances once.
- clear mid-burst with win_sel=1, and n_rst asserted mid-burst -> no further dout_valid, all outputs 0/reset values. The next event yields dout = din/2 rounded (e.g. 9 -> 5) with filled=0, then filled=1 after the second event.
